// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the cardinal NIC: register offsets and a constant-width helper.
package cardinal_nic_pkg;

  localparam logic [1:0] REG_IN_DATA  = 2'b00;
  localparam logic [1:0] REG_IN_STAT  = 2'b01;
  localparam logic [1:0] REG_OUT_DATA = 2'b10;
  localparam logic [1:0] REG_OUT_STAT = 2'b11;

  // Smallest r with 2**r >= n; used only in constant (parameter) contexts.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nic_vc_fifo.sv
// Single virtual-channel buffer: power-of-two circular FIFO with occupancy count.
module nic_vc_fifo
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               head,
  output logic [clog2(DEPTH+1)-1:0]       count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cardinal_nic_vc.sv
// Processor-side NIC with per-VC input/output buffers and a round-robin output arbiter.
module cardinal_nic_vc
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VC_W+1:0]   addr_nic,
  input  logic [DATA_W-1:0] din_nic,
  output logic [DATA_W-1:0] dout_nic,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  input  logic [VC_W-1:0]   net_vci,
  input  logic [DATA_W-1:0] net_di,
  output logic [NUM_VC-1:0] net_ri,
  output logic              net_so,
  output logic [VC_W-1:0]   net_vco,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_ro
);

  logic [DATA_W-1:0] in_head  [NUM_VC];
  logic [CNT_W-1:0]  in_cnt   [NUM_VC];
  logic [DATA_W-1:0] out_head [NUM_VC];
  logic [CNT_W-1:0]  out_cnt  [NUM_VC];
  logic [NUM_VC-1:0] in_full, in_empty, in_push, in_pop;
  logic [NUM_VC-1:0] out_full, out_empty, out_push, out_pop;

  logic              nic_en_p1;
  logic              strobe, rd_stb, wr_stb;
  logic [VC_W-1:0]   vc_sel;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] rd_val;

  logic [VC_W-1:0]   rr_ptr, lock_vc, search_vc, grant;
  logic              locked, found, xfer;
  int                idx;

  // A held nicEn yields exactly one strobe on its rising edge.
  assign strobe  = nicEn & ~nic_en_p1;
  assign rd_stb  = strobe & ~nicWrEn;
  assign wr_stb  = strobe & nicWrEn;
  assign vc_sel  = addr_nic[VC_W+1:2];
  assign reg_sel = addr_nic[1:0];

  always_comb begin
    in_push  = '0;
    in_pop   = '0;
    out_push = '0;
    out_pop  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      in_push[v]  = net_si & (net_vci == VC_W'(v)) & ~in_full[v];
      in_pop[v]   = rd_stb & (reg_sel == REG_IN_DATA) & (vc_sel == VC_W'(v)) & ~in_empty[v];
      out_push[v] = wr_stb & (reg_sel == REG_OUT_DATA) & (vc_sel == VC_W'(v)) & ~out_full[v];
      out_pop[v]  = xfer & (grant == VC_W'(v));
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    nic_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push[v]),
      .pop   (in_pop[v]),
      .din   (net_di),
      .head  (in_head[v]),
      .count (in_cnt[v]),
      .full  (in_full[v]),
      .empty (in_empty[v])
    );

    nic_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push[v]),
      .pop   (out_pop[v]),
      .din   (din_nic),
      .head  (out_head[v]),
      .count (out_cnt[v]),
      .full  (out_full[v]),
      .empty (out_empty[v])
    );
  end

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign net_ri = ~in_full;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_IN_DATA:  if (!in_empty[vc_sel]) rd_val = in_head[vc_sel];
      REG_IN_STAT:  rd_val = DATA_W'(in_cnt[vc_sel]);
      REG_OUT_STAT: rd_val = DATA_W'(CNT_W'(DEPTH) - out_cnt[vc_sel]);
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    search_vc = rr_ptr;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_VC;
      if (!found && !out_empty[idx]) begin
        found     = 1'b1;
        search_vc = VC_W'(idx);
      end
    end
  end

  // Once offered, the grant is frozen until the router takes the flit.
  assign grant   = locked ? lock_vc : search_vc;
  assign net_so  = |(~out_empty);
  assign xfer    = net_so & net_ro;
  assign net_vco = net_so ? grant : '0;
  assign net_do  = net_so ? out_head[grant] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nic_en_p1 <= 1'b0;
      dout_nic  <= '0;
      rr_ptr    <= '0;
      locked    <= 1'b0;
      lock_vc   <= '0;
    end else begin
      nic_en_p1 <= nicEn;
      if (rd_stb) dout_nic <= rd_val;
      if (xfer) begin
        rr_ptr <= VC_W'((int'(grant) + 1) % NUM_VC);
        locked <= 1'b0;
      end else if (net_so) begin
        locked  <= 1'b1;
        lock_vc <= grant;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_nic_vc.sv
// Directed bench for cardinal_nic_vc: register map, network input/output and async reset.
module tb_cardinal_nic_vc;

  localparam int DATA_W = 64;

  logic              clk;
  logic              reset;
  logic [2:0]        addr_nic;
  logic [DATA_W-1:0] din_nic;
  logic [DATA_W-1:0] dout_nic;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_si;
  logic [0:0]        net_vci;
  logic [DATA_W-1:0] net_di;
  logic [1:0]        net_ri;
  logic              net_so;
  logic [0:0]        net_vco;
  logic [DATA_W-1:0] net_do;
  logic              net_ro;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] exp;
  } rd_vec_t;

  rd_vec_t     vec_a [6];
  rd_vec_t     vec_b [6];
  rd_vec_t     vec_c [4];
  logic [63:0] fa [4];
  logic [63:0] fp [6];
  logic [63:0] o0 [4];
  logic [63:0] o1 [4];
  logic [63:0] exp_d;
  logic [0:0]  exp_v;

  cardinal_nic_vc dut (
    .clk      (clk),
    .reset    (reset),
    .addr_nic (addr_nic),
    .din_nic  (din_nic),
    .dout_nic (dout_nic),
    .nicEn    (nicEn),
    .nicWrEn  (nicWrEn),
    .net_si   (net_si),
    .net_vci  (net_vci),
    .net_di   (net_di),
    .net_ri   (net_ri),
    .net_so   (net_so),
    .net_vco  (net_vco),
    .net_do   (net_do),
    .net_ro   (net_ro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Two-cycle CPU access; dout_nic is checked in the second cycle.
  task automatic read_chk(input logic [2:0] a, input logic [63:0] exp, input string name);
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = a;
    @(posedge clk);
    @(negedge clk);
    check(name, dout_nic, exp);
    @(posedge clk); #1;
    nicEn = 1'b0;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = a; din_nic = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; addr_nic = '0; din_nic = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_vci = '0; net_di = '0; net_ro = 1'b0;

    fa[0] = 64'hA000_0000_0000_000A; fa[1] = 64'hB000_0000_0000_000B;
    fa[2] = 64'hC000_0000_0000_000C; fa[3] = 64'hD000_0000_0000_000D;
    for (int i = 0; i < 6; i++) fp[i] = 64'h5000_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 4; i++) begin
      o0[i] = 64'h0F00_0000_0000_0000 + 64'(i);
      o1[i] = 64'h1F00_0000_0000_0000 + 64'(i);
    end

    vec_a[0] = '{3'b111, 64'd4};
    vec_a[1] = '{3'b101, 64'd0};
    vec_a[2] = '{3'b011, 64'd4};
    vec_a[3] = '{3'b010, 64'd0};
    vec_a[4] = '{3'b011, 64'd4};
    vec_a[5] = '{3'b000, 64'd0};

    vec_b[0] = '{3'b001, 64'd4};
    vec_b[1] = '{3'b000, fa[0]};
    vec_b[2] = '{3'b001, 64'd3};
    vec_b[3] = '{3'b000, fa[1]};
    vec_b[4] = '{3'b001, 64'd2};
    vec_b[5] = '{3'b011, 64'd4};

    vec_c[0] = '{3'b001, 64'd0};
    vec_c[1] = '{3'b101, 64'd0};
    vec_c[2] = '{3'b111, 64'd4};
    vec_c[3] = '{3'b011, 64'd4};

    // Reset state
    #12;
    check("rst_net_ri", 64'(net_ri), 64'd3);
    check("rst_net_so", 64'(net_so), 64'd0);
    check("rst_dout", dout_nic, 64'd0);
    check("rst_net_vco", 64'(net_vco), 64'd0);
    check("rst_net_do", net_do, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) read_chk(vec_a[i].addr, vec_a[i].exp, $sformatf("vecA%0d", i));

    // Router fills VC0 input; a fifth flit is refused while held
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      net_si = 1'b1; net_vci = 1'b0; net_di = fa[i];
      @(negedge clk);
      check($sformatf("fill_ri%0d", i), 64'(net_ri), 64'd3);
    end
    @(posedge clk); #1;
    net_di = 64'hEEEE_EEEE_EEEE_EEEE;
    @(negedge clk);
    check("full_ri", 64'(net_ri), 64'd2);
    @(posedge clk);
    @(posedge clk); #1;
    net_si = 1'b0;
    check("full_ri_held", 64'(net_ri), 64'd2);

    for (int i = 0; i < 6; i++) read_chk(vec_b[i].addr, vec_b[i].exp, $sformatf("vecB%0d", i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dout_hold", dout_nic, 64'd4);

    // VC1 input: full buffer refuses a flit even when popped in the same cycle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      net_si = 1'b1; net_vci = 1'b1; net_di = fp[i];
    end
    @(posedge clk); #1;
    net_si = 1'b0;
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = 3'b100;
    net_si = 1'b1; net_vci = 1'b1; net_di = fp[4];
    @(posedge clk); #1;
    net_si = 1'b0;
    @(negedge clk);
    check("pop_full_dout", dout_nic, fp[0]);
    check("pop_full_ri", 64'(net_ri), 64'd3);
    @(posedge clk); #1;
    nicEn = 1'b0;
    read_chk(3'b101, 64'd3, "refused_cnt");

    // Simultaneous pop and push on a non-full buffer
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = 3'b100;
    net_si = 1'b1; net_vci = 1'b1; net_di = fp[5];
    @(posedge clk); #1;
    net_si = 1'b0;
    @(negedge clk);
    check("pushpop_dout", dout_nic, fp[1]);
    @(posedge clk); #1;
    nicEn = 1'b0;
    read_chk(3'b101, 64'd3, "pushpop_cnt");
    read_chk(3'b100, fp[2], "order0");
    read_chk(3'b100, fp[3], "order1");
    read_chk(3'b100, fp[5], "order2");
    read_chk(3'b101, 64'd0, "vc1_empty");

    // Output: X on VC0, Y on VC1, router stalls three cycles
    cpu_wr(3'b010, 64'h0000_0000_0000_00AA);
    cpu_wr(3'b110, 64'h0000_0000_0000_00BB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_so%0d", i), 64'(net_so), 64'd1);
      check($sformatf("stall_vco%0d", i), 64'(net_vco), 64'd0);
      check($sformatf("stall_do%0d", i), net_do, 64'h0000_0000_0000_00AA);
    end
    @(posedge clk); #1;
    net_ro = 1'b1;
    @(negedge clk);
    check("x_vco", 64'(net_vco), 64'd0);
    check("x_do", net_do, 64'h0000_0000_0000_00AA);
    @(negedge clk);
    check("y_so", 64'(net_so), 64'd1);
    check("y_vco", 64'(net_vco), 64'd1);
    check("y_do", net_do, 64'h0000_0000_0000_00BB);
    @(posedge clk); #1;
    net_ro = 1'b0;
    @(negedge clk);
    check("drained_so", 64'(net_so), 64'd0);

    // Grant lock: VC1 offered first, then higher-priority VC0 arrives
    cpu_wr(3'b110, o1[0]);
    cpu_wr(3'b010, o0[0]);
    @(negedge clk);
    check("lock_vco", 64'(net_vco), 64'd1);
    check("lock_do", net_do, o1[0]);
    for (int i = 1; i < 4; i++) begin
      cpu_wr(3'b110, o1[i]);
      cpu_wr(3'b010, o0[i]);
    end
    cpu_wr(3'b010, 64'hDEAD_DEAD_DEAD_DEAD);
    read_chk(3'b011, 64'd0, "vc0_free");
    read_chk(3'b111, 64'd0, "vc1_free");

    // Drain with router ready: VC1, VC0, VC1, ...
    @(posedge clk); #1;
    net_ro = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_v = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_d = exp_v ? o1[i/2] : o0[i/2];
      @(negedge clk);
      check($sformatf("rr_so%0d", i), 64'(net_so), 64'd1);
      check($sformatf("rr_vco%0d", i), 64'(net_vco), 64'(exp_v));
      check($sformatf("rr_do%0d", i), net_do, exp_d);
    end
    @(posedge clk); #1;
    net_ro = 1'b0;
    @(negedge clk);
    check("rr_done_so", 64'(net_so), 64'd0);

    // Async reset mid-stream
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      net_si = 1'b1; net_vci = 1'b0; net_di = 64'h6000_0000_0000_0000 + 64'(i);
    end
    @(posedge clk); #1;
    net_si = 1'b0;
    cpu_wr(3'b110, 64'h77);
    cpu_wr(3'b110, 64'h78);
    read_chk(3'b011, 64'd4, "pre_rst_free");
    @(negedge clk);
    check("pre_rst_ri", 64'(net_ri), 64'd2);
    check("pre_rst_so", 64'(net_so), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_so", 64'(net_so), 64'd0);
    check("async_ri", 64'(net_ri), 64'd3);
    check("async_dout", dout_nic, 64'd0);
    check("async_do", net_do, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) read_chk(vec_c[i].addr, vec_c[i].exp, $sformatf("vecC%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
